// File: rtl/mem_stage.sv
// Memory-access stage between EX and WB: issues loads/stores on a req/ack data port,
// aligns/extends load data and hands the result to WB, with a bypass/stall bus for ID.
module mem_stage #(
    parameter int EX_BUS_W = 107,
    parameter int WB_BUS_W = 70
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ex_valid,
    input  logic [EX_BUS_W-1:0] ex_to_me_bus,
    output logic                me_allowin,
    output logic                me_valid,
    input  logic                wb_allowin,
    output logic [WB_BUS_W-1:0] me_to_wb_bus,
    output logic [39:0]         me_fwd_bus,
    output logic                me_ale,
    output logic                data_req,
    output logic                data_wr,
    output logic [3:0]          data_wstrb,
    output logic [31:0]         data_addr,
    output logic [31:0]         data_wdata,
    input  logic                data_ack,
    input  logic [31:0]         data_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t              state, state_nx;
    logic                stage_valid;
    logic                run_q;
    logic [EX_BUS_W-1:0] bus_r;
    logic [31:0]         ld_data_r;

    function automatic logic is_misaligned(input logic mem_op, input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        return mem_op && ((size == 2'b01 && addr_lo[0]) || (size == 2'b10 && addr_lo != 2'b00));
    endfunction

    logic [31:0] pc, alu, st_data;
    logic [4:0]  waddr;
    logic        rf_we, res_from_mem, mem_we, ld_unsigned;
    logic [1:0]  size;
    assign pc           = bus_r[106:75];
    assign alu          = bus_r[74:43];
    assign st_data      = bus_r[42:11];
    assign waddr        = bus_r[10:6];
    assign rf_we        = bus_r[5];
    assign res_from_mem = bus_r[4];
    assign mem_we       = bus_r[3];
    assign size         = bus_r[2:1];
    assign ld_unsigned  = bus_r[0];

    logic mem_op, misaligned, ready_go, wb_fire, accept;
    logic in_mem, in_go_mem;
    assign mem_op     = res_from_mem | mem_we;
    assign misaligned = is_misaligned(mem_op, size, alu[1:0]);
    assign ready_go   = !mem_op || misaligned || (state == S_DONE);
    assign in_mem     = ex_to_me_bus[4] | ex_to_me_bus[3];
    assign in_go_mem  = in_mem && !is_misaligned(in_mem, ex_to_me_bus[2:1], ex_to_me_bus[44:43]);

    // Handshake: EX->ME transfers on ex_valid && me_allowin; ME->WB transfers on
    // me_valid && wb_allowin. A stage may accept in the same cycle its content leaves.
    assign me_valid   = stage_valid && ready_go;
    assign wb_fire    = me_valid && wb_allowin;
    assign me_allowin = run_q && (!stage_valid || (ready_go && wb_allowin));
    assign accept     = ex_valid && me_allowin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept && in_go_mem) state_nx = S_REQ;
            S_REQ:   if (data_ack) state_nx = S_DONE;
            S_DONE:  if (wb_fire) state_nx = (accept && in_go_mem) ? S_REQ : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    always_comb begin
        ld_byte = data_rdata[7:0];
        case (alu[1:0])
            2'b01:   ld_byte = data_rdata[15:8];
            2'b10:   ld_byte = data_rdata[23:16];
            2'b11:   ld_byte = data_rdata[31:24];
            default: ld_byte = data_rdata[7:0];
        endcase
        ld_half = alu[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (size)
            2'b00:   ld_ext = {{24{!ld_unsigned && ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{!ld_unsigned && ld_half[15]}}, ld_half};
            default: ld_ext = data_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stage_valid <= 1'b0;
            run_q       <= 1'b0;
            bus_r       <= '0;
            ld_data_r   <= '0;
        end else begin
            run_q <= 1'b1;
            if (accept) begin
                stage_valid <= 1'b1;
                bus_r       <= ex_to_me_bus;
            end else if (wb_fire) begin
                stage_valid <= 1'b0;
            end
            if (state == S_REQ && data_ack) ld_data_r <= ld_ext;
        end
    end

    logic [3:0]  st_strb;
    logic [31:0] st_wdata;
    always_comb begin
        case (size)
            2'b00: begin
                st_strb  = 4'b0001 << alu[1:0];
                st_wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                st_strb  = alu[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_strb  = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

    assign data_req   = (state == S_REQ);
    assign data_wr    = mem_we;
    assign data_addr  = alu;
    assign data_wstrb = mem_we ? st_strb : 4'b0000;
    assign data_wdata = st_wdata;

    logic        rf_we_out, ld_pending;
    logic [31:0] wdata_out;
    assign rf_we_out  = rf_we && !mem_we && !misaligned;
    assign wdata_out  = misaligned ? 32'h0 : (res_from_mem ? ld_data_r : alu);
    // ID must stall on ld_pending; wdata is only meaningful once the load is in DONE.
    assign ld_pending = stage_valid && res_from_mem && (state != S_DONE);
    assign me_ale     = me_valid && misaligned;

    assign me_to_wb_bus = {pc, rf_we_out, waddr, wdata_out};
    assign me_fwd_bus   = {stage_valid, rf_we_out, ld_pending, waddr, wdata_out};

endmodule
